// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU result queue, the ALU producer and the downstream consumer.
// master = producer/consumer side, slave = the queue itself.
interface alu_result_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] Z_IN;
    logic [3:0]       FLAGS_IN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic [3:0]       OUT_FLAGS;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [CW-1:0]    COUNT;
    logic [3:0]       STICKY_FLAGS;
    logic             STICKY_CLR;

    modport master (
        output Z_IN, FLAGS_IN, IN_VALID, OUT_READY, STICKY_CLR,
        input  IN_READY, OUT_DATA, OUT_FLAGS, OUT_VALID, COUNT, STICKY_FLAGS
    );

    modport slave (
        input  Z_IN, FLAGS_IN, IN_VALID, OUT_READY, STICKY_CLR,
        output IN_READY, OUT_DATA, OUT_FLAGS, OUT_VALID, COUNT, STICKY_FLAGS
    );
endinterface

// File: rtl/alu_result_queue.sv
// ALU output FIFO with overrun detection and sticky condition flags.
// Define ALU_STICKY_FLAGS_EN to accumulate Zero/CarryOut/Overflow across pushes.
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic CLOCK,
    input  logic RESET,
    alu_result_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [3:0]       flag_mem [DEPTH];
    logic             ovr_q, ovr_d;
    logic [2:0]       flg_acc;
    logic             full, empty, push, pop, overrun;

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign empty   = (wptr_q == rptr_q);
    assign push    = q.IN_VALID && !full;
    assign pop     = !empty && q.OUT_READY;
    assign overrun = q.IN_VALID && full;

    always_comb begin
        wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        ovr_d  = overrun | (ovr_q & ~q.STICKY_CLR);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovr_q  <= ovr_d;
        end
    end

    // Storage is deliberately unreset; only the pointers define validity.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            data_mem[wptr_q[AW-1:0]] <= q.Z_IN;
            flag_mem[wptr_q[AW-1:0]] <= q.FLAGS_IN;
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [2:0] flg_q, flg_d;

    always_comb begin
        flg_d = (flg_q & {3{~q.STICKY_CLR}}) | (push ? q.FLAGS_IN[2:0] : 3'b000);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) flg_q <= '0;
        else       flg_q <= flg_d;
    end

    assign flg_acc = flg_q;
`else
    assign flg_acc = 3'b000;
`endif

    assign q.IN_READY     = !full;
    assign q.OUT_VALID    = !empty;
    assign q.COUNT        = wptr_q - rptr_q;
    assign q.OUT_DATA     = data_mem[rptr_q[AW-1:0]];
    assign q.OUT_FLAGS    = flag_mem[rptr_q[AW-1:0]];
    assign q.STICKY_FLAGS = {ovr_q, flg_acc};
endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed test-plan sequences plus
// randomized traffic against a queue-based reference model.
module tb_alu_result_queue;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_result_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    alu_result_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .q     (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: contents as a queue of {flags, data}, plus sticky word.
    logic [35:0] mq[$];
    logic [3:0]  mst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",     64'(bus.COUNT), 64'(mq.size()));
        chk("out_valid", 64'(bus.OUT_VALID), 64'(mq.size() > 0));
        chk("in_ready",  64'(bus.IN_READY), 64'(mq.size() < DEPTH));
        chk("sticky",    64'(bus.STICKY_FLAGS), 64'(mst));
        if (mq.size() > 0) begin
            chk("out_data",  64'(bus.OUT_DATA), 64'(mq[0][31:0]));
            chk("out_flags", 64'(bus.OUT_FLAGS), 64'(mq[0][35:32]));
        end
    endtask

    // Apply one cycle of inputs (called just after a negedge), advance the model
    // across the posedge, then check outputs on the following negedge.
    task automatic cycle(input logic [31:0] z, input logic [3:0] f, input logic iv,
                         input logic ordy, input logic clr);
        bit can_push, do_pop;
        bus.Z_IN = z; bus.FLAGS_IN = f; bus.IN_VALID = iv;
        bus.OUT_READY = ordy; bus.STICKY_CLR = clr;
        can_push = iv && (mq.size() < DEPTH);
        do_pop   = ordy && (mq.size() > 0);
        @(posedge CLOCK);
        if (clr) mst = 4'h0;
        if (iv && !can_push) mst[3] = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        if (can_push) mst[2:0] = mst[2:0] | f[2:0];
`endif
        if (do_pop) void'(mq.pop_front());
        if (can_push) mq.push_back({f, z});
        @(negedge CLOCK);
        check_all();
    endtask

    initial begin
        logic [3:0] exp_st;
        bus.Z_IN = '0; bus.FLAGS_IN = '0; bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0; bus.STICKY_CLR = 1'b0;
        mst = 4'h0;
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        check_all();

        // Fill
        for (int i = 1; i <= 4; i++) begin
            cycle(32'(i), 4'h0, 1'b1, 1'b0, 1'b0);
            chk("fill_count", 64'(bus.COUNT), 64'(i));
        end
        chk("fill_in_ready", 64'(bus.IN_READY), 64'd0);
        chk("fill_head", 64'(bus.OUT_DATA), 64'd1);

        // Overrun while full
        cycle(32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("ovr_sticky3", 64'(bus.STICKY_FLAGS[3]), 64'd1);
        chk("ovr_count", 64'(bus.COUNT), 64'd4);

        // Drain in order
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 64'(bus.OUT_DATA), 64'(i));
            cycle(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("drain_count", 64'(bus.COUNT), 64'd0);
        chk("drain_ready", 64'(bus.IN_READY), 64'd1);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            cycle(32'h100 + 32'(i), 4'h0, 1'b1, 1'b1, 1'b0);
            chk("stream_count", 64'(bus.COUNT), 64'd1);
            chk("stream_data", 64'(bus.OUT_DATA), 64'h100 + 64'(i));
        end

        // Sticky flags: clear leftover overrun, then 0x4, 0x2, clear+0x1
        cycle(32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("sticky_clr", 64'(bus.STICKY_FLAGS), 64'd0);
        cycle(32'h11, 4'h4, 1'b1, 1'b1, 1'b0);
`ifdef ALU_STICKY_FLAGS_EN
        exp_st = 4'h4;
`else
        exp_st = 4'h0;
`endif
        chk("sticky_a", 64'(bus.STICKY_FLAGS), 64'(exp_st));
        cycle(32'h22, 4'h2, 1'b1, 1'b1, 1'b0);
`ifdef ALU_STICKY_FLAGS_EN
        exp_st = 4'h6;
`endif
        chk("sticky_b", 64'(bus.STICKY_FLAGS), 64'(exp_st));
        cycle(32'h33, 4'h1, 1'b1, 1'b1, 1'b1);
`ifdef ALU_STICKY_FLAGS_EN
        exp_st = 4'h1;
`endif
        chk("sticky_c", 64'(bus.STICKY_FLAGS), 64'(exp_st));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom, 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Async reset with three entries queued
        for (int i = 0; i < 8; i++) cycle(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(32'h200 + 32'(i), 4'h7, 1'b1, 1'b0, 1'b0);
        cycle(32'hBAD, 4'h7, 1'b1, 1'b0, 1'b0);
        cycle(32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_count", 64'(bus.COUNT), 64'd3);
        chk("pre_rst_sticky3", 64'(bus.STICKY_FLAGS[3]), 64'd1);
        bus.OUT_READY = 1'b0;
        #2 RESET = 1'b1;
        #1;
        mq.delete();
        mst = 4'h0;
        chk("rst_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_count", 64'(bus.COUNT), 64'd0);
        chk("rst_sticky", 64'(bus.STICKY_FLAGS), 64'd0);
        chk("rst_ready", 64'(bus.IN_READY), 64'd1);
        @(negedge CLOCK);
        RESET = 1'b0;
        check_all();
        cycle(32'h55, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_head", 64'(bus.OUT_DATA), 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Output-side buffer for the Functional Unit ALU. It accepts one 32-bit result and its 4-bit flag word per cycle from the ALU output (Z, FLAGS) and holds them in a small FIFO. Results are released to the downstream consumer (register writeback or interconnect) through a valid/ready handshake. Because the ALU cannot stall, the block also detects and records overrun, and can optionally accumulate sticky condition flags across accepted results.

## Interface
Parameters:
- DEPTH, 4: number of entries; must be a power of two, 2..16.
- WIDTH, 32: data width; matches the ALU Z width.

Ports:
- CLOCK, input, 1: single clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- Z_IN, input, WIDTH: ALU result.
- FLAGS_IN, input, 4: ALU flags, {reserved, Zero, CarryOut, Overflow}.
- IN_VALID, input, 1: Z_IN/FLAGS_IN carry a result this cycle.
- IN_READY, output, 1: space available; high when count < DEPTH.
- OUT_DATA, output, WIDTH: head entry data.
- OUT_FLAGS, output, 4: head entry flags.
- OUT_VALID, output, 1: head entry valid; high when count > 0.
- OUT_READY, input, 1: consumer accepts the head this cycle.
- COUNT, output, clog2(DEPTH)+1: current occupancy.
- STICKY_FLAGS, output, 4: {Overrun, Zero, CarryOut, Overflow} accumulators.
- STICKY_CLR, input, 1: synchronous clear of STICKY_FLAGS.

## Operation
- Push happens when IN_VALID && IN_READY: entry written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop happens when OUT_VALID && OUT_READY: the read pointer increments modulo DEPTH.
- Pointers are clog2(DEPTH)+1 bits with a wrap bit.
  - full = (pointer indices equal) && (wrap bits differ).
  - empty = (pointers equal).
  - COUNT = wptr - rptr.
- IN_READY depends only on registered state. It has no combinational path from OUT_READY, so a push is refused when full even if a pop happens the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and COUNT is unchanged.
- Push with OUT_READY high while empty: the entry is written this cycle and OUT_VALID rises next cycle. There is no same-cycle bypass.
- Overrun (IN_VALID && !IN_READY): the incoming result is dropped and FIFO contents are unchanged. STICKY_FLAGS[3] is set regardless of configuration.
- OUT_DATA/OUT_FLAGS are driven from storage at the read pointer. When empty, they hold the last-read entry's value and are don't-care to the consumer.
- Popping or writing memory when not permitted is never performed. Storage has no reset; only pointers and sticky state reset.
- STICKY_CLR clears all STICKY_FLAGS bits. If a set event occurs in the same cycle as STICKY_CLR, set wins for that bit.

## Timing
- Reset (async assert, synchronous deassert expected from the reset synchronizer):
  - Pointers are 0, COUNT = 0, OUT_VALID = 0, IN_READY = 1, STICKY_FLAGS = 0.
- Reset asserted mid-operation empties the queue immediately. All stored entries are lost.
- Latency from push to OUT_VALID: 1 cycle when empty, otherwise queue position + 1.
- Throughput: 1 push and 1 pop per cycle sustained.
- All outputs are registered or decoded directly from registers.

## Configuration
- ALU_STICKY_FLAGS_EN defined:
  - On every push, STICKY_FLAGS[2:0] |= FLAGS_IN[2:0].
  - FLAGS_IN[3] is ignored.
- ALU_STICKY_FLAGS_EN undefined:
  - STICKY_FLAGS[2:0] are tied to 0 and the accumulator logic is removed.
  - STICKY_FLAGS[3] (overrun) remains functional.
  - STICKY_CLR still clears bit 3.

## Test plan
- Reset then fill: push 0x00000001..0x00000004 with flags 0x0 and OUT_READY=0.
  - COUNT steps 1..4; IN_READY=0 after the 4th push; OUT_DATA=0x00000001.
- Drain in order: with the queue full, hold OUT_READY=1 for 4 cycles.
  - OUT_DATA sequence 1,2,3,4; OUT_VALID falls after the 4th pop; COUNT=0; IN_READY=1.
- Overrun: with the queue full, push 0xDEADBEEF.
  - Value never appears at OUT_DATA; STICKY_FLAGS[3]=1; COUNT stays 4.
- Streaming with wrap: push and pop every cycle for 20 cycles with incrementing data.
  - COUNT constant at 1 after the first cycle; output equals input delayed by 1 cycle across pointer wrap.
- Sticky flags (macro defined): push flags 0x4, then 0x2; assert STICKY_CLR together with a push of flags 0x1.
  - STICKY_FLAGS 0x4, then 0x6, then 0x1. With the macro undefined, the same stimulus gives 0x0 throughout.
- Async reset mid-stream: assert RESET with COUNT=3, between clock edges.
  - OUT_VALID=0, COUNT=0, STICKY_FLAGS=0 immediately, before the next CLOCK edge.
